sd_card_fsm: RTL and testbench

- Card-side (responder) command state machine for the SD bus; the counterpart of the host initialisation/transfer FSM.
- Sits between a card-side CMD-line receiver/response transmitter and a card-side DAT-line block engine.
- Used as an SD card model in simulation and as the core of the card emulator.
- Tracks SD card state (idle→ready→ident→stby→tran→data/rcv/prg, ina), assigns RCA, builds R1/R2/R3/R6 responses and launches block reads/writes.

---
 rtl/sd_pkg.sv | 42 ++++
 rtl/sd_card_status.sv | 46 ++++
 rtl/sd_card_fsm.sv | 273 +++++++++++++++++++++++++++
 tb/tb_sd_card_fsm.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - SD card responder shared encodings
package sd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_READY = 4'd1,
    ST_IDENT = 4'd2,
    ST_STBY  = 4'd3,
    ST_TRAN  = 4'd4,
    ST_DATA  = 4'd5,
    ST_RCV   = 4'd6,
    ST_PRG   = 4'd7,
    ST_INA   = 4'd8
  } card_state_t;

  typedef enum logic [1:0] {
    RESP_R1 = 2'd0,
    RESP_R2 = 2'd1,
    RESP_R3 = 2'd2,
    RESP_R6 = 2'd3
  } resp_type_t;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD2   = 6'd2;
  localparam logic [5:0] CMD3   = 6'd3;
  localparam logic [5:0] CMD7   = 6'd7;
  localparam logic [5:0] CMD15  = 6'd15;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD24  = 6'd24;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD6  = 6'd6;
  localparam logic [5:0] ACMD41 = 6'd41;

  localparam logic [5:0] RESP_IDX_NONE = 6'h3F;

  localparam int STAT_OOR       = 31;
  localparam int STAT_CRC       = 23;
  localparam int STAT_ILL       = 22;
  localparam int STAT_STATE_LSB = 9;
  localparam int STAT_APP       = 5;

endpackage

// File: rtl/sd_card_status.sv
// rtl/sd_card_status.sv - sticky card status register merged with current state and APP_CMD
module sd_card_status
  import sd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_set_oor,
  input  logic        i_set_crc,
  input  logic        i_set_ill,
  input  logic        i_clear,
  input  card_state_t i_state,
  input  logic        i_app,
  output logic [31:0] o_status
);

  logic r_oor;
  logic r_crc;
  logic r_ill;

  // Errors raised by the command being answered appear in its own R1.
  always_comb begin
    o_status = '0;
    o_status[STAT_OOR] = r_oor | i_set_oor;
    o_status[STAT_CRC] = r_crc | i_set_crc;
    o_status[STAT_ILL] = r_ill | i_set_ill;
    o_status[STAT_STATE_LSB +: 4] = i_state;
    o_status[STAT_APP] = i_app;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_oor <= 1'b0;
      r_crc <= 1'b0;
      r_ill <= 1'b0;
    end else if (i_clear) begin
      r_oor <= 1'b0;
      r_crc <= 1'b0;
      r_ill <= 1'b0;
    end else begin
      r_oor <= r_oor | i_set_oor;
      r_crc <= r_crc | i_set_crc;
      r_ill <= r_ill | i_set_ill;
    end
  end

endmodule

// File: rtl/sd_card_fsm.sv
// rtl/sd_card_fsm.sv - SD card responder command FSM; SD_CARD_OOR_EN enables the block range check
module sd_card_fsm
  import sd_pkg::*;
#(
  parameter logic [15:0] RCA        = 16'h1234,
  parameter logic [1:0]  OCR_VOLT   = 2'b11,
  parameter int          BUSY_POLLS = 2,
  parameter logic [22:0] NUM_BLOCKS = 23'd1024,
  parameter int          PRG_CYCLES = 8
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        icmd_valid,
  input  logic [5:0]  icmd_index,
  input  logic [31:0] icmd_arg,
  input  logic        icmd_crc_fail,
  input  logic        iresp_done,
  input  logic        idata_done,
  input  logic        idata_crc_fail,
  output logic        ostart_resp,
  output logic [1:0]  oresp_type,
  output logic [5:0]  oresp_index,
  output logic [31:0] oresp_arg,
  output logic        ostart_rd,
  output logic        ostart_wr,
  output logic [22:0] oaddr,
  output logic        owide_bus,
  output logic [3:0]  ostate
);

  localparam logic [3:0] LP_BUSY_POLLS = 4'(BUSY_POLLS);
  localparam logic [7:0] LP_PRG_LAST   = 8'(PRG_CYCLES - 1);

  card_state_t r_state, w_state;
  logic        r_app, w_app;
  logic [3:0]  r_busy_cnt, w_busy_cnt;
  logic        r_rca_valid, w_rca_valid;
  logic        r_pending;
  logic        r_rd_pend, w_rd_pend;
  logic        r_wr_pend, w_wr_pend;
  logic [7:0]  r_prg_cnt, w_prg_cnt;
  logic        w_wide;
  logic [22:0] w_addr;

  logic        w_resp;
  resp_type_t  w_resp_type;
  logic [5:0]  w_resp_index;
  logic        w_ocr_ready;
  logic [31:0] w_resp_arg;
  logic [31:0] w_status;
  logic        w_set_oor, w_set_crc, w_set_ill;

  logic        w_accept;
  logic        w_rca_match;
  logic        w_oor;
  logic        w_addressed_state;
  logic        w_unused;

  assign w_accept    = icmd_valid & ~r_pending & (r_state != ST_INA);
  assign w_rca_match = r_rca_valid & (icmd_arg[31:16] == RCA);
  assign w_addressed_state = (r_state == ST_STBY) || (r_state == ST_TRAN) ||
                             (r_state == ST_DATA) || (r_state == ST_RCV)  ||
                             (r_state == ST_PRG);
  assign w_unused    = ^icmd_arg[8:2];

`ifdef SD_CARD_OOR_EN
  assign w_oor = (icmd_arg[31:9] >= NUM_BLOCKS);
`else
  assign w_oor = 1'b0;
`endif

  always_comb begin
    w_state      = r_state;
    w_app        = r_app;
    w_busy_cnt   = r_busy_cnt;
    w_rca_valid  = r_rca_valid;
    w_rd_pend    = r_rd_pend & ~iresp_done;
    w_wr_pend    = r_wr_pend & ~iresp_done;
    w_prg_cnt    = r_prg_cnt;
    w_wide       = owide_bus;
    w_addr       = oaddr;
    w_resp       = 1'b0;
    w_resp_type  = RESP_R1;
    w_resp_index = icmd_index;
    w_ocr_ready  = 1'b0;
    w_set_oor    = 1'b0;
    w_set_crc    = 1'b0;
    w_set_ill    = 1'b0;

    // Data-side progress; a command decoded below may still override the state.
    case (r_state)
      ST_DATA: if (idata_done) w_state = ST_TRAN;
      ST_RCV: begin
        if (idata_crc_fail) begin
          w_state = ST_TRAN;
        end else if (idata_done) begin
          w_state   = ST_PRG;
          w_prg_cnt = LP_PRG_LAST;
        end
      end
      ST_PRG: begin
        if (r_prg_cnt == 8'd0) w_state = ST_TRAN;
        else                   w_prg_cnt = r_prg_cnt - 8'd1;
      end
      default: ;
    endcase

    if (w_accept && icmd_crc_fail) begin
      w_set_crc = 1'b1;
    end else if (w_accept) begin
      w_app = 1'b0;
      if (icmd_index == CMD0) begin
        w_state     = ST_IDLE;
        w_busy_cnt  = 4'd0;
        w_rca_valid = 1'b0;
        w_wide      = 1'b0;
        w_rd_pend   = 1'b0;
        w_wr_pend   = 1'b0;
      end else if (icmd_index == CMD55) begin
        if (((r_state == ST_STBY) || (r_state == ST_TRAN)) && !w_rca_match) begin
          w_set_ill = 1'b1;
        end else begin
          w_app  = 1'b1;
          w_resp = 1'b1;
        end
      end else if (icmd_index == CMD15 && w_rca_match && w_addressed_state) begin
        w_state   = ST_INA;
        w_rd_pend = 1'b0;
        w_wr_pend = 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_app && icmd_index == ACMD41) begin
              if ((icmd_arg[21:20] & OCR_VOLT) == 2'b00) begin
                w_state = ST_INA;
              end else begin
                w_resp       = 1'b1;
                w_resp_type  = RESP_R3;
                w_resp_index = RESP_IDX_NONE;
                if (r_busy_cnt < LP_BUSY_POLLS) begin
                  w_busy_cnt = r_busy_cnt + 4'd1;
                end else begin
                  w_ocr_ready = 1'b1;
                  w_state     = ST_READY;
                end
              end
            end else begin
              w_set_ill = 1'b1;
            end
          end
          ST_READY: begin
            if (icmd_index == CMD2) begin
              w_resp       = 1'b1;
              w_resp_type  = RESP_R2;
              w_resp_index = RESP_IDX_NONE;
              w_state      = ST_IDENT;
            end else begin
              w_set_ill = 1'b1;
            end
          end
          ST_IDENT: begin
            if (icmd_index == CMD3) begin
              w_resp      = 1'b1;
              w_resp_type = RESP_R6;
              w_state     = ST_STBY;
              w_rca_valid = 1'b1;
            end else begin
              w_set_ill = 1'b1;
            end
          end
          ST_STBY: begin
            // A select aimed at another card is silently ignored.
            if (icmd_index == CMD7) begin
              if (w_rca_match) begin
                w_resp  = 1'b1;
                w_state = ST_TRAN;
              end
            end else begin
              w_set_ill = 1'b1;
            end
          end
          ST_TRAN: begin
            if (r_app && icmd_index == ACMD6) begin
              w_wide = (icmd_arg[1:0] == 2'b10);
              w_resp = 1'b1;
            end else if (icmd_index == CMD17 || icmd_index == CMD24) begin
              w_resp = 1'b1;
              w_addr = icmd_arg[31:9];
              if (w_oor) begin
                w_set_oor = 1'b1;
              end else if (icmd_index == CMD17) begin
                w_state   = ST_DATA;
                w_rd_pend = 1'b1;
              end else begin
                w_state   = ST_RCV;
                w_wr_pend = 1'b1;
              end
            end else begin
              w_set_ill = 1'b1;
            end
          end
          default: w_set_ill = 1'b1;
        endcase
      end
    end
  end

  sd_card_status u_status (
    .i_clk     (iclk),
    .i_rst     (irst),
    .i_set_oor (w_set_oor),
    .i_set_crc (w_set_crc),
    .i_set_ill (w_set_ill),
    .i_clear   (w_resp && (w_resp_type == RESP_R1)),
    .i_state   (r_state),
    .i_app     (w_app),
    .o_status  (w_status)
  );

  always_comb begin
    w_resp_arg = 32'd0;
    case (w_resp_type)
      RESP_R1: w_resp_arg = w_status;
      RESP_R3: w_resp_arg = {w_ocr_ready, 9'd0, OCR_VOLT, 20'd0};
      RESP_R6: w_resp_arg = {RCA, w_status[23], w_status[22], w_status[19], w_status[12:0]};
      default: w_resp_arg = 32'd0;
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state     <= ST_IDLE;
      r_app       <= 1'b0;
      r_busy_cnt  <= 4'd0;
      r_rca_valid <= 1'b0;
      r_pending   <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_prg_cnt   <= 8'd0;
      ostart_resp <= 1'b0;
      oresp_type  <= 2'd0;
      oresp_index <= 6'd0;
      oresp_arg   <= 32'd0;
      ostart_rd   <= 1'b0;
      ostart_wr   <= 1'b0;
      oaddr       <= 23'd0;
      owide_bus   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_app       <= w_app;
      r_busy_cnt  <= w_busy_cnt;
      r_rca_valid <= w_rca_valid;
      r_rd_pend   <= w_rd_pend;
      r_wr_pend   <= w_wr_pend;
      r_prg_cnt   <= w_prg_cnt;
      oaddr       <= w_addr;
      owide_bus   <= w_wide;
      ostart_resp <= w_resp;
      ostart_rd   <= iresp_done & r_rd_pend;
      ostart_wr   <= iresp_done & r_wr_pend;
      if (w_resp)          r_pending <= 1'b1;
      else if (iresp_done) r_pending <= 1'b0;
      if (w_resp) begin
        oresp_type  <= w_resp_type;
        oresp_index <= w_resp_index;
        oresp_arg   <= w_resp_arg;
      end
    end
  end

  assign ostate = r_state;

endmodule

// File: tb/tb_sd_card_fsm.sv
// tb/tb_sd_card_fsm.sv - randomized scoreboard bench for sd_card_fsm
module tb_sd_card_fsm;

  localparam logic [15:0] RCA        = 16'h1234;
  localparam int          BUSY_POLLS = 2;
  localparam int          NUM_BLOCKS = 1024;
  localparam int          PRG_CYCLES = 8;
`ifdef SD_CARD_OOR_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        icmd_valid = 1'b0;
  logic [5:0]  icmd_index = 6'd0;
  logic [31:0] icmd_arg = 32'd0;
  logic        icmd_crc_fail = 1'b0;
  logic        iresp_done = 1'b0;
  logic        idata_done = 1'b0;
  logic        idata_crc_fail = 1'b0;
  logic        ostart_resp;
  logic [1:0]  oresp_type;
  logic [5:0]  oresp_index;
  logic [31:0] oresp_arg;
  logic        ostart_rd;
  logic        ostart_wr;
  logic [22:0] oaddr;
  logic        owide_bus;
  logic [3:0]  ostate;

  sd_card_fsm #(
    .RCA(RCA), .OCR_VOLT(2'b11), .BUSY_POLLS(BUSY_POLLS),
    .NUM_BLOCKS(23'(NUM_BLOCKS)), .PRG_CYCLES(PRG_CYCLES)
  ) dut (
    .iclk(iclk), .irst(irst), .icmd_valid(icmd_valid), .icmd_index(icmd_index),
    .icmd_arg(icmd_arg), .icmd_crc_fail(icmd_crc_fail), .iresp_done(iresp_done),
    .idata_done(idata_done), .idata_crc_fail(idata_crc_fail),
    .ostart_resp(ostart_resp), .oresp_type(oresp_type), .oresp_index(oresp_index),
    .oresp_arg(oresp_arg), .ostart_rd(ostart_rd), .ostart_wr(ostart_wr),
    .oaddr(oaddr), .owide_bus(owide_bus), .ostate(ostate)
  );

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [5:0]  idx;
    logic [31:0] arg;
    int          due;
  } resp_t;

  typedef struct {
    bit          wr;
    logic [22:0] addr;
    int          due;
  } xfer_t;

  typedef struct {
    bit          has;
    logic [1:0]  t;
    logic [5:0]  idx;
    logic [31:0] arg;
    bit          xf;
    bit          wr;
    logic [22:0] addr;
  } exp_t;

  resp_t exp_resp[$];
  xfer_t exp_xfer[$];

  // Monitor: every pulse the DUT emits must match the oldest expectation.
  always @(negedge iclk) begin
    if (!irst) begin
      if (ostart_resp) begin
        if (exp_resp.size() == 0) begin
          chk("resp_unexpected", {62'd0, oresp_type}, 64'hFFFF);
        end else begin
          resp_t e;
          e = exp_resp.pop_front();
          chk("resp_type", oresp_type, e.t);
          chk("resp_index", oresp_index, e.idx);
          chk("resp_arg", oresp_arg, e.arg);
          chk("resp_time", cyc, e.due);
        end
      end
      if (ostart_rd || ostart_wr) begin
        if (exp_xfer.size() == 0) begin
          chk("xfer_unexpected", {ostart_rd, ostart_wr}, 64'hFFFF);
        end else begin
          xfer_t x;
          x = exp_xfer.pop_front();
          chk("xfer_kind", {ostart_rd, ostart_wr}, x.wr ? 2'b01 : 2'b10);
          chk("xfer_addr", oaddr, x.addr);
          chk("xfer_time", cyc, x.due);
        end
      end
    end
  end

  // Reference card model.
  int m_state, m_busy;
  bit m_app, m_wide, m_oor, m_crc, m_ill;

  task automatic model_reset();
    m_state = 0; m_busy = 0; m_app = 0; m_wide = 0;
    m_oor = 0; m_crc = 0; m_ill = 0;
  endtask

  task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit crc,
                           output exp_t e);
    int ps;
    bit app, rca_ok, r1, ill, oor;
    e = '{default: '0};
    if (m_state == 8) return;
    if (crc) begin
      m_crc = 1;
      return;
    end
    ps = m_state;
    app = m_app;
    m_app = 0;
    rca_ok = (arg[31:16] == RCA);
    r1 = 0;
    ill = 0;
    if (idx == 0) begin
      m_state = 0; m_busy = 0; m_wide = 0;
      return;
    end
    if (idx == 55) begin
      if ((ps == 3 || ps == 4) && !rca_ok) ill = 1;
      else begin m_app = 1; r1 = 1; end
    end else if (idx == 15 && rca_ok && ps >= 3 && ps <= 7) begin
      m_state = 8;
      return;
    end else if (app && idx == 41 && ps == 0) begin
      if (arg[21:20] == 2'b00) begin
        m_state = 8;
        return;
      end
      e.has = 1; e.t = 2; e.idx = 6'h3F;
      if (m_busy < BUSY_POLLS) begin
        m_busy++;
        e.arg = 32'h0030_0000;
      end else begin
        e.arg = 32'h8030_0000;
        m_state = 1;
      end
    end else if (idx == 2 && ps == 1) begin
      e.has = 1; e.t = 1; e.idx = 6'h3F; e.arg = 0;
      m_state = 2;
    end else if (idx == 3 && ps == 2) begin
      e.has = 1; e.t = 3; e.idx = 3;
      e.arg = (32'(RCA) << 16) | (32'(m_crc) << 15) | (32'(m_ill) << 14) | (32'(ps) << 9);
      m_state = 3;
    end else if (idx == 7 && ps == 3) begin
      if (!rca_ok) return;
      r1 = 1;
      m_state = 4;
    end else if (app && idx == 6 && ps == 4) begin
      m_wide = (arg[1:0] == 2'b10);
      r1 = 1;
    end else if ((idx == 17 || idx == 24) && ps == 4) begin
      r1 = 1;
      e.addr = arg[31:9];
      oor = OOR_EN && (int'(arg[31:9]) >= NUM_BLOCKS);
      if (oor) m_oor = 1;
      else begin
        e.xf = 1;
        e.wr = (idx == 24);
        m_state = e.wr ? 6 : 5;
      end
    end else begin
      ill = 1;
    end
    if (ill) m_ill = 1;
    if (r1) begin
      e.has = 1; e.t = 0; e.idx = idx;
      e.arg = (32'(m_oor) << 31) | (32'(m_crc) << 23) | (32'(m_ill) << 22) |
              (32'(ps) << 9) | (32'(m_app) << 5);
      m_oor = 0; m_crc = 0; m_ill = 0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit crc,
                          input bit drop);
    exp_t e;
    model_cmd(idx, arg, crc, e);
    @(posedge iclk); #1;
    if (e.has) exp_resp.push_back(resp_t'{t: e.t, idx: e.idx, arg: e.arg, due: cyc + 1});
    icmd_valid = 1; icmd_index = idx; icmd_arg = arg; icmd_crc_fail = crc;
    @(posedge iclk); #1;
    icmd_valid = 0; icmd_crc_fail = 0;
    if (e.has) begin
      if (drop) begin
        icmd_valid = 1; icmd_index = 6'd55; icmd_arg = {RCA, 16'h0};
        @(posedge iclk); #1;
        icmd_valid = 0;
      end
      repeat ($urandom_range(0, 3)) @(posedge iclk);
      @(posedge iclk); #1;
      iresp_done = 1;
      if (e.xf) exp_xfer.push_back(xfer_t'{wr: e.wr, addr: e.addr, due: cyc + 1});
      @(posedge iclk); #1;
      iresp_done = 0;
    end
    @(posedge iclk); #1;
  endtask

  task automatic check_state(input string nm);
    @(negedge iclk);
    chk(nm, ostate, m_state);
  endtask

  task automatic finish_xfer(input bit done, input bit crc);
    repeat ($urandom_range(1, 4)) @(posedge iclk);
    @(posedge iclk); #1;
    idata_done = done; idata_crc_fail = crc;
    @(posedge iclk); #1;
    idata_done = 0; idata_crc_fail = 0;
    if (m_state == 5 && done) begin
      m_state = 4;
    end else if (m_state == 6) begin
      if (crc) m_state = 4;
      else if (done) begin
        for (int k = 0; k < PRG_CYCLES; k++) begin
          @(negedge iclk);
          chk("prg_state", ostate, 7);
        end
        m_state = 4;
      end
    end
    check_state("ostate_after_xfer");
  endtask

  logic [5:0] ill_list [3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] arg;
    int blk;
    int r;
    ill_list[0] = 6'd2; ill_list[1] = 6'd3; ill_list[2] = 6'd41;
    model_reset();
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    chk("rst_ostate", ostate, 0);
    chk("rst_outputs", {ostart_resp, ostart_rd, ostart_wr, owide_bus, oresp_type, oresp_index},
        0);
    chk("rst_arg_addr", {oresp_arg, 9'd0, oaddr}, 0);
    @(posedge iclk); #1;
    irst = 0;

    // Power-up: CMD55 / ACMD41 until the card leaves busy.
    for (int it = 0; it < 12 && m_state == 0; it++) begin
      if (it > 0 && $urandom_range(0, 3) == 0) send_cmd(6'd17, $urandom, 0, 0);
      if (it > 0 && $urandom_range(0, 3) == 0) send_cmd(6'($urandom), $urandom, 1, 0);
      send_cmd(6'd55, 32'd0, 0, 0);
      arg = (it == 0) ? 32'h8030_0000
                      : {1'b1, 9'($urandom), 2'($urandom_range(1, 3)), 20'($urandom)};
      send_cmd(6'd41, arg, 0, 0);
    end
    check_state("init_ready");

    send_cmd(6'd2, $urandom, 0, 0);
    check_state("after_cmd2");
    send_cmd(6'd3, $urandom, 0, 0);
    check_state("after_cmd3");
    send_cmd(6'd7, 32'h4321_0000, 0, 0);
    check_state("cmd7_wrong_rca");
    send_cmd(6'd7, 32'h1234_0000, 0, 0);
    check_state("after_cmd7");

    send_cmd(6'd55, {RCA, 16'($urandom)}, 0, 0);
    send_cmd(6'd6, 32'd2, 0, 0);
    @(negedge iclk);
    chk("owide_bus", owide_bus, m_wide);

    send_cmd(6'd17, 32'h0000_0400, 0, 0);
    check_state("after_cmd17");
    finish_xfer(1, 0);

`ifdef SD_CARD_OOR_EN
    send_cmd(6'd24, {23'd1024, 9'd0}, 0, 0);
    check_state("oor_stays_tran");
    send_cmd(6'd55, {RCA, 16'd0}, 0, 0);
    send_cmd(6'd6, 32'd0, 0, 0);
`endif

    send_cmd(6'd24, {23'd77, 9'd0}, 0, 0);
    check_state("after_cmd24");
    finish_xfer(1, 0);

    // Randomized traffic in the transfer state.
    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        send_cmd(ill_list[$urandom_range(0, 2)], $urandom, 0, 0);
      end else if (r == 1) begin
        send_cmd(6'($urandom), $urandom, 1, 0);
      end else if (r == 2) begin
        send_cmd(6'd55, {RCA, 16'($urandom)}, 0, (it % 3) == 0);
        send_cmd(6'd6, $urandom, 0, 0);
        @(negedge iclk);
        chk("owide_bus_rand", owide_bus, m_wide);
      end else begin
        blk = $urandom_range(0, NUM_BLOCKS - 1);
        if (OOR_EN && $urandom_range(0, 3) == 0) blk = NUM_BLOCKS + $urandom_range(0, 100);
        arg = {23'(blk), 9'($urandom)};
        send_cmd(($urandom_range(0, 1) == 1) ? 6'd24 : 6'd17, arg, 0, 0);
        if (m_state == 5) begin
          finish_xfer(1, 0);
        end else if (m_state == 6) begin
          r = $urandom_range(0, 3);
          if (r == 0)      finish_xfer(0, 1);
          else if (r == 1) finish_xfer(1, 1);
          else             finish_xfer(1, 0);
        end
      end
      check_state("ostate_rand");
    end

    send_cmd(6'd15, 32'h1234_0000, 0, 0);
    check_state("after_cmd15");
    send_cmd(6'd0, 32'd0, 0, 0);
    send_cmd(6'd55, 32'd0, 0, 0);
    check_state("ina_ignores");

    repeat (4) @(posedge iclk);
    chk("resp_queue_empty", exp_resp.size(), 0);
    chk("xfer_queue_empty", exp_xfer.size(), 0);

    #1 irst = 1;
    model_reset();
    @(negedge iclk);
    chk("rst2_ostate", ostate, 0);
    chk("rst2_outputs", {ostart_resp, ostart_rd, ostart_wr, owide_bus, oaddr}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
